// File: rtl/if_id_skid_buffer.sv
// IF/ID two-entry skid buffer: {PC+4, instruction} from fetch, presented in order to decode.
// Optional stall counter on stall_cnt_o is built when IFID_STALL_CNT_EN is defined.
module if_id_skid_buffer #(
  parameter int unsigned              PC_W      = 32,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    in_pc_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    out_pc_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [15:0]        out_imm16_o
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]    head_pc_p1, skid_pc_p1;
  logic [INSTR_W-1:0] head_instr_p1, skid_instr_p1;
  logic               vld_p1;

  logic accept, consume;
  logic load_head_in, load_head_skid, load_skid;

  // Handshake flags are pure decodes of the state register, so out_ready_i never reaches in_ready_o.
  assign vld_p1      = (state != EMPTY);
  assign in_ready_o  = (state != FULL);
  assign out_valid_o = vld_p1;

  assign accept  = in_valid_i && in_ready_o;
  assign consume = vld_p1 && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_nxt      = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage p1: head and skid storage; cleared on reset so outputs never carry X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_pc_p1    <= '0;
      head_instr_p1 <= '0;
      skid_pc_p1    <= '0;
      skid_instr_p1 <= '0;
    end else begin
      if (load_head_in) begin
        head_pc_p1    <= in_pc_i;
        head_instr_p1 <= in_instr_i;
      end else if (load_head_skid) begin
        head_pc_p1    <= skid_pc_p1;
        head_instr_p1 <= skid_instr_p1;
      end
      if (load_skid) begin
        skid_pc_p1    <= in_pc_i;
        skid_instr_p1 <= in_instr_i;
      end
    end
  end

  assign out_pc_o    = vld_p1 ? head_pc_p1    : '0;
  assign out_instr_o = vld_p1 ? head_instr_p1 : NOP_INSTR;
  assign out_imm16_o = out_instr_o[15:0];

`ifdef IFID_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt_p1;

  // Counts decode stalls; flush has no effect on it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                       stall_cnt_p1 <= '0;
    else if (vld_p1 && !out_ready_i) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign stall_cnt_o = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: directed test-plan steps then random traffic against a queue model.
module tb_if_id_skid_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_pc_i, in_instr_i, out_pc_o, out_instr_o;
  logic [15:0] out_imm16_o;
`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  if_id_skid_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_instr_o(out_instr_o), .out_imm16_o(out_imm16_o)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } word_t;
  word_t       mq[$];
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_pc, e_instr;
    e_pc    = (mq.size() > 0) ? mq[0].pc    : 32'h0;
    e_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
    chk("in_ready",  {31'd0, in_ready_o},  {31'd0, mq.size() < 2});
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, mq.size() > 0});
    chk("out_pc",    out_pc_o,    e_pc);
    chk("out_instr", out_instr_o, e_instr);
    chk("out_imm16", {16'd0, out_imm16_o}, {16'd0, e_instr[15:0]});
`ifdef IFID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, m_cnt);
`endif
  endtask

  task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit ordy);
    rst_i = r; flush_i = f; in_valid_i = iv; in_pc_i = pc; in_instr_i = ins; out_ready_i = ordy;
  endtask

  task automatic tick();
    bit acc, con, stall;
    acc   = in_valid_i && (mq.size() < 2);
    con   = (mq.size() > 0) && out_ready_i;
    stall = (mq.size() > 0) && !out_ready_i;
    @(posedge clk_i);
    if (rst_i) begin
      mq.delete();
      m_cnt = 32'h0;
    end else begin
      if (stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (flush_i) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: in_pc_i, instr: in_instr_i});
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    m_cnt = 32'h0;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_in_ready",  {31'd0, in_ready_o},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);

    // pass-through
    drive(0, 0, 1, 32'h4, 32'h2008000A, 1);
    tick();
    chk("pt_pc",    out_pc_o,    32'h4);
    chk("pt_instr", out_instr_o, 32'h2008000A);
    chk("pt_imm",   {16'd0, out_imm16_o}, 32'h000A);
    drive(0, 0, 0, 0, 0, 1);
    tick();

    // backpressure fill
    drive(0, 0, 1, 32'h8, 32'h8C090010, 0);
    tick();
    drive(0, 0, 1, 32'hC, 32'h2009FFFF, 0);
    tick();
    chk("bp_full_ready", {31'd0, in_ready_o}, 32'd0);
    drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
    tick();
    chk("bp_head_imm", {16'd0, out_imm16_o}, 32'h0010);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("bp_second",     out_instr_o, 32'h2009FFFF);
    chk("bp_second_imm", {16'd0, out_imm16_o}, 32'hFFFF);
    tick();
    chk("bp_drained", {31'd0, out_valid_o}, 32'd0);

    // streaming: accept and consume together in ONE
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 32'h100 + 4 * i, 32'hA000_0000 + i, 1);
      tick();
      chk("stream_word",  out_instr_o, 32'hA000_0000 + i);
      chk("stream_ready", {31'd0, in_ready_o}, 32'd1);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();

    // flush from FULL with a word arriving
    drive(0, 0, 1, 32'h20, 32'h1111_0001, 0);
    tick();
    drive(0, 0, 1, 32'h24, 32'h1111_0002, 0);
    tick();
    drive(0, 1, 1, 32'h28, 32'h12345678, 0);
    tick();
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_instr", out_instr_o, 32'h0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("flush_no_ghost", out_instr_o, 32'h0);

    // reset beats flush and handshake
    drive(0, 0, 1, 32'h30, 32'h2222_0001, 0);
    tick();
    drive(1, 1, 1, 32'h34, 32'h2222_0002, 1);
    tick();
    chk("rstpri_pc",    out_pc_o, 32'h0);
    chk("rstpri_ready", {31'd0, in_ready_o}, 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("rstpri_lost", {31'd0, out_valid_o}, 32'd0);

`ifdef IFID_STALL_CNT_EN
    drive(0, 0, 1, 32'h40, 32'h3333_0001, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    chk("stall_5", stall_cnt_o, 32'd5);
    drive(0, 1, 0, 0, 0, 1);
    tick();
    chk("stall_after_flush", stall_cnt_o, 32'd5);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("stall_reset", stall_cnt_o, 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70,
            $urandom, $urandom, $urandom_range(0, 99) < 55);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
